div_operand_feeder: RTL and testbench

DIV_OPERAND_FEEDER -- requirements
Module: div_operand_feeder

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_feed_fifo.sv | 61 ++++++
 rtl/div_operand_feeder.sv | 135 +++++++++++++
 tb/tb_div_operand_feeder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the divider operand feeder: FSM states, default
// length-field width and the operand bit-length helper.
package div_pkg;

    localparam int LEN_W_DEFAULT = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        ACCEPT,
        BUSY
    } state_t;

    // Position of the most significant 1 plus one; zero reports a length of 1.
    function automatic logic [6:0] bit_length(input logic [63:0] value);
        logic [6:0] len;
        len = 7'd1;
        for (int i = 0; i < 64; i++) begin
            if (value[i]) begin
                len = 7'(i + 1);
            end
        end
        return len;
    endfunction

endpackage

// File: rtl/div_feed_fifo.sv
// Operand-pair FIFO with a combinational head read.
// Pointers wrap modulo DEPTH, which must be a power of two.
module div_feed_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage carries no reset; emptiness is tracked solely by the count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/div_operand_feeder.sv
// Queues dividend/divisor pairs and hands them to a done-handshaked divider.
// Define DIV_FEED_ZERO_CHECK_EN to drop zero-divisor pairs with an err_div0 pulse.
module div_operand_feeder
    import div_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = LEN_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [DATA_W-1:0]      wr_dividend,
    input  logic [DATA_W-1:0]      wr_divisor,
    input  logic                   div_done,
    output logic                   div_inp,
    output logic [DATA_W-1:0]      div_dividend,
    output logic [DATA_W-1:0]      div_divisor,
    output logic [LEN_W-1:0]       div_dividend_length,
    output logic [LEN_W-1:0]       div_divisor_length,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_div0
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_rst_done;
    logic [DATA_W-1:0]       r_dividend;
    logic [DATA_W-1:0]       r_divisor;
    logic [LEN_W-1:0]        r_dividend_len;
    logic [LEN_W-1:0]        r_divisor_len;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_load;
    logic                    w_drop;
    logic                    w_full;
    logic                    w_empty;
    logic [2*DATA_W-1:0]     w_head;
    logic [DATA_W-1:0]       w_head_dividend;
    logic [DATA_W-1:0]       w_head_divisor;

    // r_rst_done keeps the producer stalled until the first edge after reset.
    assign wr_ready        = r_rst_done & ~w_full;
    assign w_push          = wr_valid & wr_ready;
    assign w_head_dividend = w_head[2*DATA_W-1:DATA_W];
    assign w_head_divisor  = w_head[DATA_W-1:0];

`ifdef DIV_FEED_ZERO_CHECK_EN
    assign w_drop = (w_head_divisor == '0);
`else
    assign w_drop = 1'b0;
`endif

    div_feed_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({wr_dividend, wr_divisor}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        div_inp      = 1'b0;
        err_div0     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && div_done) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_pop = 1'b1;
                if (w_drop) begin
                    err_div0     = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_load       = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                div_inp      = 1'b1;
                w_state_next = ACCEPT;
            end
            ACCEPT: begin
                if (!div_done) begin
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (div_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rst_done     <= 1'b0;
            r_dividend     <= '0;
            r_divisor      <= '0;
            r_dividend_len <= LEN_W'(1);
            r_divisor_len  <= LEN_W'(1);
        end else begin
            r_state    <= w_state_next;
            r_rst_done <= 1'b1;
            if (w_load) begin
                r_dividend     <= w_head_dividend;
                r_divisor      <= w_head_divisor;
                r_dividend_len <= LEN_W'(bit_length(64'(w_head_dividend)));
                r_divisor_len  <= LEN_W'(bit_length(64'(w_head_divisor)));
            end
        end
    end

    assign div_dividend        = r_dividend;
    assign div_divisor         = r_divisor;
    assign div_dividend_length = r_dividend_len;
    assign div_divisor_length  = r_divisor_len;

endmodule

// File: tb/tb_div_operand_feeder.sv
// Directed and randomized bench for div_operand_feeder; the reference is a pair
// queue plus arithmetic bit lengths. Honours DIV_FEED_ZERO_CHECK_EN like the DUT.
module tb_div_operand_feeder;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = 6;
`ifdef DIV_FEED_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_dividend;
    logic [DW-1:0] wr_divisor;
    logic          div_done;
    logic          div_inp;
    logic [DW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic [LW-1:0] div_dividend_length;
    logic [LW-1:0] div_divisor_length;
    logic [3:0]    count;
    logic          err_div0;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];
    logic [DW-1:0] last_a;
    logic [DW-1:0] last_b;

    div_operand_feeder #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .LEN_W  (LW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_valid            (wr_valid),
        .wr_ready            (wr_ready),
        .wr_dividend         (wr_dividend),
        .wr_divisor          (wr_divisor),
        .div_done            (div_done),
        .div_inp             (div_inp),
        .div_dividend        (div_dividend),
        .div_divisor         (div_divisor),
        .div_dividend_length (div_dividend_length),
        .div_divisor_length  (div_divisor_length),
        .count               (count),
        .err_div0            (err_div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Smallest n with v < 2**n, never below 1.
    function automatic int exp_len(input logic [63:0] v);
        int n;
        n = 1;
        while ((v >> n) != 0) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] rnd_val();
        logic [DW-1:0] v;
        v = $urandom;
        v = v >> $urandom_range(0, 31);
        if ($urandom_range(0, 7) == 0) v = '0;
        return v;
    endfunction

    // Called at a negedge; returns at the following negedge.
    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit exp_rdy;
        exp_rdy = (q_a.size() < DEPTH);
        chk("wr_ready", wr_ready, exp_rdy);
        wr_valid    = 1'b1;
        wr_dividend = a;
        wr_divisor  = b;
        @(negedge clk);
        wr_valid = 1'b0;
        if (exp_rdy) begin
            q_a.push_back(a);
            q_b.push_back(b);
        end
        $display("push   dividend=%0d divisor=%0d accepted=%0d", a, b, exp_rdy);
    endtask

    task automatic check_out(input string tag);
        chk({tag, " dividend"}, div_dividend, last_a);
        chk({tag, " divisor"}, div_divisor, last_b);
        chk({tag, " dividend_len"}, div_dividend_length, exp_len(last_a));
        chk({tag, " divisor_len"}, div_divisor_length, exp_len(last_b));
    endtask

    // Starts in START's negedge; leaves the FSM idle with div_done low.
    task automatic post_issue(input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, " no_reissue_while_done_high"}, div_inp, 0);
        end
        div_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, " no_reissue_while_busy"}, div_inp, 0);
        div_done = 1'b1;
        @(negedge clk);
        div_done = 1'b0;
    endtask

    task automatic serve_one(input string tag);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit drop;
        bit hit;
        int lat;
        if (q_a.size() == 0) return;
        a = q_a.pop_front();
        b = q_b.pop_front();
        drop = ZC && (b == '0);
        div_done = 1'b1;
        hit = 1'b0;
        lat = 0;
        while (!hit && lat < 20) begin
            @(negedge clk);
            hit = div_inp | err_div0;
            if (!hit) lat++;
        end
        chk({tag, " event_seen"}, hit, 1);
        chk({tag, " latency"}, lat, drop ? 0 : 1);
        chk({tag, " err_div0"}, err_div0, drop);
        chk({tag, " div_inp"}, div_inp, !drop);
        if (drop) begin
            div_done = 1'b0;
            @(negedge clk);
            chk({tag, " err_single_cycle"}, err_div0, 0);
        end else begin
            last_a = a;
            last_b = b;
        end
        check_out(tag);
        if (!drop) post_issue(tag);
        $display("serve  %s dividend=%0d divisor=%0d dropped=%0d", tag, a, b, drop);
    endtask

    initial begin
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        bit seen;
        int k;
        int m;

        rst_n       = 1'b0;
        wr_valid    = 1'b0;
        wr_dividend = '0;
        wr_divisor  = '0;
        div_done    = 1'b0;
        last_a      = '0;
        last_b      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst count", count, 0);
        chk("rst div_inp", div_inp, 0);
        chk("rst err_div0", err_div0, 0);
        chk("rst wr_ready", wr_ready, 0);
        check_out("rst");
        rst_n = 1'b1;
        #1;
        chk("rst wr_ready_at_release", wr_ready, 0);
        @(negedge clk);
        chk("rst wr_ready_after_clock", wr_ready, 1);

        // Single pair, 3-cycle issue latency
        div_done = 1'b1;
        push(32'd67, 32'd14);
        chk("t036 cycle1 div_inp", div_inp, 0);
        chk("t036 count", count, 1);
        @(negedge clk);
        chk("t036 cycle2 div_inp", div_inp, 0);
        @(negedge clk);
        chk("t036 cycle3 div_inp", div_inp, 1);
        last_a = q_a.pop_front();
        last_b = q_b.pop_front();
        chk("t036 dividend_len_7", div_dividend_length, 7);
        chk("t036 divisor_len_4", div_divisor_length, 4);
        check_out("t036");
        post_issue("t036");

        // Fill to full; ninth push refused
        for (int i = 0; i < 9; i++) push(rnd_val(), rnd_val());
        chk("t037 count_full", count, 8);
        chk("t037 wr_ready_full", wr_ready, 0);
        for (int i = 0; i < 8; i++) serve_one("t037 drain");
        chk("t037 count_drained", count, 0);

        // Ordered issue of three pairs
        push(32'd13, 32'd77);
        push(32'd6, 32'd14);
        push(32'd156, 32'd69);
        for (int i = 0; i < 3; i++) serve_one("t038");

        // Reset while BUSY with three pairs queued
        for (int i = 0; i < 4; i++) push(rnd_val(), rnd_val() | 32'd1);
        div_done = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = div_inp;
        end
        chk("t039 issued", div_inp, 1);
        last_a = q_a.pop_front();
        last_b = q_b.pop_front();
        check_out("t039 before_reset");
        div_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t039 count_in_busy", count, 3);
        rst_n = 1'b0;
        #1;
        q_a.delete();
        q_b.delete();
        last_a = '0;
        last_b = '0;
        chk("t039 count", count, 0);
        chk("t039 div_inp", div_inp, 0);
        chk("t039 wr_ready", wr_ready, 0);
        check_out("t039 in_reset");
        div_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (div_inp) seen = 1'b1;
        end
        chk("t039 no_issue_after_release", seen, 0);
        chk("t039 count_after_release", count, 0);
        div_done = 1'b0;
        @(negedge clk);

        // Zero divisor handling
        push(32'd57, 32'd0);
        push(32'd57, 32'd12);
        serve_one("t040 first");
        serve_one("t040 second");
        chk("t040 final_len_dividend", div_dividend_length, 6);
        chk("t040 final_len_divisor", div_divisor_length, 4);

        // Simultaneous push and pop at count 3
        push(rnd_val(), rnd_val() | 32'd1);
        push(rnd_val(), rnd_val());
        push(rnd_val(), rnd_val());
        div_done = 1'b1;
        @(negedge clk);
        chk("t041 count_in_load", count, 3);
        push(rnd_val(), rnd_val());
        chk("t041 count_after_push_pop", count, 3);
        chk("t041 div_inp", div_inp, 1);
        last_a = q_a.pop_front();
        last_b = q_b.pop_front();
        check_out("t041");
        post_issue("t041");
        while (q_a.size() > 0) serve_one("t041 drain");

        // Randomized rounds, many pointer wraps
        for (int r = 0; r < 14; r++) begin
            k = $urandom_range(1, 5);
            for (int i = 0; i < k; i++) push(rnd_val(), rnd_val());
            chk("rand count_after_push", count, q_a.size());
            m = $urandom_range(0, q_a.size());
            for (int i = 0; i < m; i++) serve_one("rand");
            chk("rand count_after_serve", count, q_a.size());
        end
        while (q_a.size() > 0) serve_one("rand drain");
        chk("rand final_count", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
